// File: rtl/counter_pkg.sv
// Shared definitions for the counter command sequencer: counter control codes,
// sequencer FSM state encoding and the press-priority helper.
package counter_pkg;

   // Command codes understood by the 4-bit up/down/load counter
   localparam logic [1:0] CTRL_CLEAR = 2'd0;
   localparam logic [1:0] CTRL_UP    = 2'd1;
   localparam logic [1:0] CTRL_DOWN  = 2'd2;
   localparam logic [1:0] CTRL_LOAD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN_UP   = 2'd1,
      ST_RUN_DOWN = 2'd2
   } state_t;

   // The single press acted on in a cycle after priority resolution
   typedef enum logic [2:0] {
      PR_NONE = 3'd0,
      PR_CLR  = 3'd1,
      PR_LOAD = 3'd2,
      PR_RUN  = 3'd3,
      PR_UP   = 3'd4,
      PR_DOWN = 3'd5
   } press_t;

   // clr > load > run > up > down; lower-priority coincident presses are dropped
   function automatic press_t pick_press(input logic clr, input logic ld,
                                         input logic run, input logic up,
                                         input logic down);
      if (clr)       return PR_CLR;
      else if (ld)   return PR_LOAD;
      else if (run)  return PR_RUN;
      else if (up)   return PR_UP;
      else if (down) return PR_DOWN;
      else           return PR_NONE;
   endfunction

endpackage

// File: rtl/counter_cmd_ctrl_if.sv
// Bus between the command sequencer and its surroundings: raw buttons, switch
// value, counter feedback and the counter command outputs.
interface counter_cmd_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_clr;
   logic       btn_load;
   logic       btn_run;
   logic [3:0] sw_val;
   logic [3:0] count_in;
   logic [1:0] control;
   logic [3:0] load;
   logic       running;

   // Sequencer side
   modport master (
      input  btn_up, btn_down, btn_clr, btn_load, btn_run, sw_val, count_in,
      output control, load, running
   );

   // Environment side (buttons, switches, counter)
   modport slave (
      output btn_up, btn_down, btn_clr, btn_load, btn_run, sw_val, count_in,
      input  control, load, running
   );
endinterface

// File: rtl/btn_conditioner.sv
// One push-button path: synchroniser register, optional debounce (macro
// CMD_DEBOUNCE_EN) and rising-edge detect producing a one-cycle press pulse.
// A button that is already high when reset is released never produces a
// press until it has been seen low at least once.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   logic sync_lvl;
   logic deb_lvl;
   logic prev_lvl;
   logic armed;

   // Synchroniser stage for the raw button level
   always_ff @(posedge clk) begin
      if (reset) sync_lvl <= 1'b0;
      else       sync_lvl <= raw;
   end

`ifdef CMD_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [CW-1:0] diff_cnt;

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_lvl  <= 1'b0;
         diff_cnt <= '0;
      end else if (sync_lvl != deb_lvl) begin
         if (diff_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_lvl  <= sync_lvl;
            diff_cnt <= '0;
         end else begin
            diff_cnt <= diff_cnt + 1'b1;
         end
      end else begin
         diff_cnt <= '0;
      end
   end
`else
   // Depth parameter has no effect here; the synchronised level is used directly
   assign deb_lvl = sync_lvl && (DEBOUNCE_CYCLES > 0);
`endif

   // Previous debounced level and post-reset arming for the edge detector
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_lvl <= 1'b0;
         armed    <= 1'b0;
      end else begin
         prev_lvl <= deb_lvl;
         armed    <= armed | ~raw;
      end
   end

   assign press = armed & deb_lvl & ~prev_lvl;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Counter command sequencer. Converts button presses into single-cycle
// counter commands, runs a prescaled free-running up/down mode and holds the
// counter between commands by reloading its own value. Optional button
// debounce is enabled with the macro CMD_DEBOUNCE_EN.
module counter_cmd_ctrl
   import counter_pkg::*;
#(
   parameter int PRESCALE        = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic                clk,
   input logic                reset,
   counter_cmd_ctrl_if.master bus
);

   localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

   logic          press_up;
   logic          press_down;
   logic          press_clr;
   logic          press_load;
   logic          press_run;
   press_t        sel;

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic [1:0]    ctrl_q;
   logic [1:0]    ctrl_next;
   logic          ld_cmd_q;
   logic          ld_cmd_next;
   logic [3:0]    ld_val_q;
   logic          running_q;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
      .clk(clk), .reset(reset), .raw(bus.btn_up),   .press(press_up));
   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
      .clk(clk), .reset(reset), .raw(bus.btn_down), .press(press_down));
   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
      .clk(clk), .reset(reset), .raw(bus.btn_clr),  .press(press_clr));
   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_load (
      .clk(clk), .reset(reset), .raw(bus.btn_load), .press(press_load));
   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_run (
      .clk(clk), .reset(reset), .raw(bus.btn_run),  .press(press_run));

   assign sel = pick_press(press_clr, press_load, press_run, press_up, press_down);

   // State, prescaler and registered command outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         presc     <= '0;
         ctrl_q    <= CTRL_LOAD;
         ld_cmd_q  <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state     <= state_next;
         presc     <= presc_next;
         ctrl_q    <= ctrl_next;
         ld_cmd_q  <= ld_cmd_next;
         running_q <= (state_next != ST_IDLE);
      end
   end

   // Switch value captured every edge; only consumed in a load-command cycle
   always_ff @(posedge clk) begin
      ld_val_q <= bus.sw_val;
   end

   // Next-state: run toggles IDLE/RUN, up/down only redirect an active run
   always_comb begin
      state_next = state;
      case (sel)
         PR_RUN:  state_next = (state == ST_IDLE) ? ST_RUN_UP : ST_IDLE;
         PR_UP:   if (state != ST_IDLE) state_next = ST_RUN_UP;
         PR_DOWN: if (state != ST_IDLE) state_next = ST_RUN_DOWN;
         default: state_next = state;
      endcase
   end

   // Command and prescaler decode for the selected press or run-mode step
   always_comb begin
      ctrl_next   = CTRL_LOAD;
      ld_cmd_next = 1'b0;
      presc_next  = presc;
      case (sel)
         PR_CLR: begin
            ctrl_next  = CTRL_CLEAR;
            presc_next = '0;
         end
         PR_LOAD: begin
            ld_cmd_next = 1'b1;
            presc_next  = '0;
         end
         PR_RUN: presc_next = '0;
         PR_UP: begin
            if (state == ST_IDLE) ctrl_next  = CTRL_UP;
            else                  presc_next = '0;
         end
         PR_DOWN: begin
            if (state == ST_IDLE) ctrl_next  = CTRL_DOWN;
            else                  presc_next = '0;
         end
         default: begin
            if (state != ST_IDLE) begin
               if (presc == PRESC_LAST) begin
                  presc_next = '0;
                  ctrl_next  = (state == ST_RUN_UP) ? CTRL_UP : CTRL_DOWN;
               end else begin
                  presc_next = presc + 1'b1;
               end
            end
         end
      endcase
   end

   assign bus.control = ctrl_q;
   assign bus.running = running_q;
   // Hold reloads the live counter value so the cycle after a step stays put
   assign bus.load    = ld_cmd_q ? ld_val_q : bus.count_in;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Self-checking bench for counter_cmd_ctrl with an attached 4-bit counter.
// A behavioural reference model predicts command, load, running and the
// resulting count each cycle; directed sequences are followed by random
// button activity with occasional resets.
module tb_counter_cmd_ctrl;
   import counter_pkg::*;

   localparam int PRESCALE = 4;
   localparam int DEB      = 3;
   localparam int B_UP = 0, B_DOWN = 1, B_CLR = 2, B_LOAD = 3, B_RUN = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] count;

   counter_cmd_ctrl_if bus();

   counter_cmd_ctrl #(.PRESCALE(PRESCALE), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // The counter being driven
   always @(posedge clk) begin
      if (reset) count <= 4'd0;
      else case (bus.control)
         2'd0:    count <= 4'd0;
         2'd1:    count <= count + 4'd1;
         2'd2:    count <= count - 4'd1;
         default: count <= bus.load;
      endcase
   end
   assign bus.count_in = count;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit           m_sync[5];
   bit           m_lvl[5];
   bit           m_lvl_old[5];
   bit           m_armed[5];
   bit [DEB-1:0] m_win[5];       // most recent synchronised samples
   int           m_dir;          // +1 running up, -1 running down, 0 stopped
   int           m_steps_left;   // edges until next automatic step
   int           m_cnt;
   int           exp_ctrl, exp_ldcmd, exp_ldval, exp_running;

   task automatic model_step(input bit [4:0] raw, input bit [3:0] sw, input bit rst);
      bit pr[5];
      if (rst) begin
         for (int b = 0; b < 5; b++) begin
            m_sync[b] = 0; m_lvl[b] = 0; m_lvl_old[b] = 0; m_armed[b] = 0; m_win[b] = '0;
         end
         m_dir = 0; m_steps_left = PRESCALE; m_cnt = 0;
         exp_ctrl = 3; exp_ldcmd = 0; exp_ldval = sw; exp_running = 0;
         return;
      end
      // counter reacts to the command issued after the previous edge
      case (exp_ctrl)
         0: m_cnt = 0;
         1: m_cnt = (m_cnt + 1) % 16;
         2: m_cnt = (m_cnt + 15) % 16;
         default: if (exp_ldcmd != 0) m_cnt = exp_ldval;
      endcase
      for (int b = 0; b < 5; b++) pr[b] = m_armed[b] && m_lvl[b] && !m_lvl_old[b];
      exp_ctrl = 3; exp_ldcmd = 0; exp_ldval = sw;
      if (pr[B_CLR]) begin
         exp_ctrl = 0; m_steps_left = PRESCALE;
      end else if (pr[B_LOAD]) begin
         exp_ldcmd = 1; m_steps_left = PRESCALE;
      end else if (pr[B_RUN]) begin
         m_dir = (m_dir == 0) ? 1 : 0; m_steps_left = PRESCALE;
      end else if (pr[B_UP]) begin
         if (m_dir == 0) exp_ctrl = 1;
         else begin m_dir = 1; m_steps_left = PRESCALE; end
      end else if (pr[B_DOWN]) begin
         if (m_dir == 0) exp_ctrl = 2;
         else begin m_dir = -1; m_steps_left = PRESCALE; end
      end else if (m_dir != 0) begin
         m_steps_left--;
         if (m_steps_left == 0) begin
            exp_ctrl = (m_dir > 0) ? 1 : 2;
            m_steps_left = PRESCALE;
         end
      end
      exp_running = (m_dir != 0) ? 1 : 0;
      // button levels advance past this edge
      for (int b = 0; b < 5; b++) begin
         m_lvl_old[b] = m_lvl[b];
         m_armed[b]   = m_armed[b] | !raw[b];
`ifdef CMD_DEBOUNCE_EN
         m_win[b] = {m_win[b][DEB-2:0], m_sync[b]};
         if ((m_lvl[b] && m_win[b] == '0) || (!m_lvl[b] && m_win[b] == '1))
            m_lvl[b] = !m_lvl[b];
`else
         m_lvl[b] = raw[b];
`endif
         m_sync[b] = raw[b];
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic run_cycle(input bit [4:0] b, input bit [3:0] sw, input bit rst);
      @(negedge clk);
      reset        = rst;
      bus.btn_up   = b[B_UP];
      bus.btn_down = b[B_DOWN];
      bus.btn_clr  = b[B_CLR];
      bus.btn_load = b[B_LOAD];
      bus.btn_run  = b[B_RUN];
      bus.sw_val   = sw;
      model_step(b, sw, rst);
      @(posedge clk);
      #1;
      check_val("control", int'(bus.control), exp_ctrl);
      check_val("running", int'(bus.running), exp_running);
      check_val("load", int'(bus.load), (exp_ldcmd != 0) ? exp_ldval : m_cnt);
      check_val("count", int'(count), m_cnt);
   endtask

   // Hold a button mask high, then low, long enough to pass debounce
   task automatic press_btn(input bit [4:0] mask, input bit [3:0] sw);
      for (int i = 0; i < DEB + 2; i++) run_cycle(mask, sw, 1'b0);
      for (int i = 0; i < DEB + 2; i++) run_cycle(5'b0, sw, 1'b0);
   endtask

   initial begin
      bit [4:0] lv;
      bit [3:0] sw;
      reset = 1'b1;
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_clr = 0; bus.btn_load = 0; bus.btn_run = 0;
      bus.sw_val = 4'd0;

      for (int i = 0; i < 3; i++)  run_cycle(5'b0, 4'd0, 1'b1);
      for (int i = 0; i < 20; i++) run_cycle(5'b0, 4'd0, 1'b0);

      press_btn(5'b00001, 4'd0);                  // single up
      press_btn(5'b01000, 4'd9);                  // load 9
      press_btn(5'b00010, 4'd3);                  // single down
      press_btn(5'b01000, 4'd14);                 // load 14 before running
      press_btn(5'b10000, 4'd0);                  // run: 14,15,0,1...
      for (int i = 0; i < 3 * PRESCALE; i++) run_cycle(5'b0, 4'd0, 1'b0);
      press_btn(5'b00010, 4'd0);                  // switch to run down
      for (int i = 0; i < 3 * PRESCALE; i++) run_cycle(5'b0, 4'd0, 1'b0);
      press_btn(5'b10000, 4'd0);                  // stop
      press_btn(5'b01101, 4'd7);                  // clr+load+up together
      press_btn(5'b10000, 4'd0);                  // run again
      run_cycle(5'b0, 4'd0, 1'b0);
      run_cycle(5'b0, 4'd0, 1'b1);                // reset mid-run
      for (int i = 0; i < 8; i++) run_cycle(5'b0, 4'd0, 1'b0);
      // button held through reset, then bounce pattern
      run_cycle(5'b00001, 4'd0, 1'b1);
      for (int i = 0; i < 8; i++) run_cycle(5'b00001, 4'd0, 1'b0);
      for (int i = 0; i < 8; i++) run_cycle(5'b0, 4'd0, 1'b0);
      run_cycle(5'b00001, 4'd0, 1'b0);
      run_cycle(5'b00000, 4'd0, 1'b0);
      run_cycle(5'b00001, 4'd0, 1'b0);
      run_cycle(5'b00000, 4'd0, 1'b0);
      for (int i = 0; i < 8; i++) run_cycle(5'b0, 4'd0, 1'b0);

      // random button activity
      lv = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, 5) == 0) lv[b] = ~lv[b];
         sw = 4'($urandom_range(0, 15));
         run_cycle(lv, sw, ($urandom_range(0, 299) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/counter_cmd_ctrl.md
# counter_cmd_ctrl

Command sequencer that sits directly upstream of the 4-bit up/down/load counter and drives its `control[1:0]` and `load[3:0]` inputs. It turns push-button presses and a 4-bit switch value into single-cycle counter commands, with an optional free-running mode that steps the counter at a prescaled rate. The counter has no "hold" code, so between commands this block holds the count by issuing LOAD with the counter's own value, fed back on `count_in`.

## Interface
- `PRESCALE`, 8: cycles between automatic steps in run mode; legal range ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required before a button level is accepted; legal range ≥2. Ignored without `CMD_DEBOUNCE_EN`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_clr`, `btn_load`, `btn_run`  in  1 each  raw button levels; a press is a rising edge.
- `sw_val`  in  4  value to load on a `btn_load` press.
- `count_in`  in  4  counter output, fed back for hold.
- `control`  out  2  counter command: 0=CLEAR, 1=UP, 2=DOWN, 3=LOAD.
- `load`  out  4  counter load value.
- `running`  out  1  high in RUN_UP or RUN_DOWN.

## Operation
- Button path, per button:
  - Register once (sync stage).
  - Debounce (optional).
  - Rising-edge detect against the previous debounced level, giving a 1-cycle press pulse.
- `sw_val` is sampled on the same edge at which the load press pulse is acted on.
- Press priority when pulses coincide: clr > load > run > up > down. Only the highest-priority press is acted on; the lower ones are dropped.
- FSM states are IDLE, RUN_UP and RUN_DOWN.
- IDLE:
  - up press: one UP command.
  - down press: one DOWN command.
  - run press: go to RUN_UP.
- RUN_UP / RUN_DOWN:
  - run press: go to IDLE, no step.
  - up press: go to RUN_UP, no step, prescaler restarts.
  - down press: go to RUN_DOWN, no step, prescaler restarts.
  - Prescaler counts 0..PRESCALE-1. At terminal count it emits one UP (RUN_UP) or DOWN (RUN_DOWN), then wraps to 0.
- clr press (any state): one CLEAR command; state unchanged; prescaler restarts.
- load press (any state): one LOAD with the sampled `sw_val`; state unchanged; prescaler restarts.
- All other cycles are hold: `control`=3 and `load`=`count_in`.
- `control` is registered. `load` is a combinational mux: the registered load value in a load-command cycle, otherwise `count_in`. This keeps hold correct in the cycle after a step.
- Wrap-around is the counter's native modulo-16 behaviour. No saturation: 15 UP gives 0, 0 DOWN gives 15.

## Timing
- Reset values:
  - `control`=3, `running`=0, `load`=`count_in`.
  - State IDLE, prescaler 0.
  - Sync and debounced levels 0, debounce counters 0.
- A button held high through reset produces no press after reset.
- Latency without debounce: button sampled high at edge N; command on `control` after edge N+1; counter updates at edge N+2.
- Latency with debounce: command on `control` after edge N+DEBOUNCE_CYCLES+1.
- Every command lasts exactly one cycle, then `control` returns to 3.
- Run-mode step period is exactly PRESCALE cycles. The first step comes PRESCALE cycles after entering a RUN state or after a prescaler restart.
- `running` is registered with the state and changes on the same edge as the state.
- Reset asserted mid-run or mid-debounce: all state returns to reset values at that edge, and no command is emitted.

## Configuration
- `CMD_DEBOUNCE_EN` defined: each button has a debounce counter. The debounced level flips only after the sync value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- `CMD_DEBOUNCE_EN` not defined: debounced level = sync register, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `counter_pkg` holds:
  - control code constants CTRL_CLEAR=0, CTRL_UP=1, CTRL_DOWN=2, CTRL_LOAD=3;
  - FSM state encoding (IDLE, RUN_UP, RUN_DOWN).
- One sub-module, `btn_conditioner`, instantiated 5×. It contains the sync register, the optional debounce and the edge detect, and outputs a press pulse.
- Top level: FSM, prescaler, priority select, output register and load mux.

## Test plan
- Reset, with `count_in`=0 and no presses → `control`=3, `load`=0, `running`=0, held for 20 cycles.
- No debounce: `btn_up` high at edge 10 and held → `control`=1 for one cycle after edge 11, then 3; with counter attached, count goes 0→1 and holds.
- `sw_val`=9 and `btn_load` press → one LOAD with `load`=9; counter reads 9; the following hold cycles show `load`=9.
- PRESCALE=4: run press from IDLE → `running`=1, UP every 4 cycles, counter 14,15,0,1; down press → DOWN steps resume 4 cycles later; run press → `running`=0, holds.
- clr, load and up pressed on the same edge → only CLEAR is issued and counter reads 0; reset asserted mid-run → IDLE with `control`=3.
- With `CMD_DEBOUNCE_EN` and DEBOUNCE_CYCLES=3: pulse pattern 1,0,1,0 produces no command; a stable high yields a command after edge N+4.
